// File: rtl/spi_input_frontend_if.sv
// rtl/spi_input_frontend_if.sv - SPI pin, conditioned-level and shift-register signal bundle
interface spi_input_frontend_if #(
    parameter int WIDTH = 8
);
    logic             sclk_pin;
    logic             mosi_pin;
    logic             cs_pin;
    logic             sclk_cond;
    logic             mosi_cond;
    logic             cs_cond;
    logic             sclk_posedge;
    logic             mosi_posedge;
    logic             cs_posedge;
    logic             sclk_negedge;
    logic             mosi_negedge;
    logic             cs_negedge;
    logic             parallel_load;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;

    modport slave (
        input  sclk_pin, mosi_pin, cs_pin, parallel_load, parallel_in,
        output sclk_cond, mosi_cond, cs_cond,
        output sclk_posedge, mosi_posedge, cs_posedge,
        output sclk_negedge, mosi_negedge, cs_negedge,
        output parallel_out, serial_out
    );

    modport master (
        output sclk_pin, mosi_pin, cs_pin, parallel_load, parallel_in,
        input  sclk_cond, mosi_cond, cs_cond,
        input  sclk_posedge, mosi_posedge, cs_posedge,
        input  sclk_negedge, mosi_negedge, cs_negedge,
        input  parallel_out, serial_out
    );
endinterface

// File: rtl/spi_input_frontend.sv
// rtl/spi_input_frontend.sv - SPI pin synchronizer/debouncer with edge pulses and 8-bit shift register
module spi_input_frontend #(
    parameter int COUNTER_WIDTH = 3,
    parameter int WAIT_TIME     = 3,
    parameter int WIDTH         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_input_frontend_if.slave  bus
);
    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

    // channel index: 0 = sclk, 1 = mosi, 2 = cs
    logic [2:0] pin;
    logic [2:0] cond;
    logic [2:0] rise;
    logic [2:0] fall;

    assign pin = {bus.cs_pin, bus.mosi_pin, bus.sclk_pin};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic                     sync0;
        logic                     sync1;
        logic                     level;
        logic                     pulse_rise;
        logic                     pulse_fall;
        logic [COUNTER_WIDTH-1:0] count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync0      <= 1'b0;
                sync1      <= 1'b0;
                level      <= 1'b0;
                pulse_rise <= 1'b0;
                pulse_fall <= 1'b0;
                count      <= '0;
            end else begin
                sync0      <= pin[i];
                sync1      <= sync0;
                pulse_rise <= 1'b0;
                pulse_fall <= 1'b0;
                if (level == sync1) begin
                    count <= '0;
                end else if (count == WAIT_CNT) begin
                    // sync1 has disagreed long enough: accept the new level
                    level      <= sync1;
                    count      <= '0;
                    pulse_rise <= sync1;
                    pulse_fall <= ~sync1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end

        assign cond[i] = level;
        assign rise[i] = pulse_rise;
        assign fall[i] = pulse_fall;
    end

    assign bus.sclk_cond    = cond[0];
    assign bus.mosi_cond    = cond[1];
    assign bus.cs_cond      = cond[2];
    assign bus.sclk_posedge = rise[0];
    assign bus.mosi_posedge = rise[1];
    assign bus.cs_posedge   = rise[2];
    assign bus.sclk_negedge = fall[0];
    assign bus.mosi_negedge = fall[1];
    assign bus.cs_negedge   = fall[2];

    logic [WIDTH-1:0] shift_reg;

    // parallel load outranks a coincident sclk rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (bus.parallel_load) begin
            shift_reg <= bus.parallel_in;
        end else if (rise[0]) begin
            shift_reg <= {shift_reg[WIDTH-2:0], cond[1]};
        end
    end

    assign bus.parallel_out = shift_reg;
    assign bus.serial_out   = shift_reg[WIDTH-1];
endmodule

// File: tb/tb_spi_input_frontend.sv
// tb/tb_spi_input_frontend.sv - randomized and directed bench for spi_input_frontend
module tb_spi_input_frontend;
    localparam int WAIT_TIME = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    spi_input_frontend_if #(.WIDTH(8)) bus ();

    spi_input_frontend #(
        .COUNTER_WIDTH(3),
        .WAIT_TIME    (WAIT_TIME),
        .WIDTH        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a level is accepted once the twice-registered pin has disagreed with
    // the current level on WAIT_TIME+1 consecutive clock edges.
    bit [2:0] m_cond, m_rise, m_fall;
    bit       m_hist[3][2];
    int       m_run[3];
    int       m_sr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cond = '0; m_rise = '0; m_fall = '0; m_sr = 0;
            for (int i = 0; i < 3; i++) begin
                m_run[i] = 0; m_hist[i][0] = 0; m_hist[i][1] = 0;
            end
        end else begin
            logic [2:0] p;
            p = {bus.cs_pin, bus.mosi_pin, bus.sclk_pin};
            if (bus.parallel_load) m_sr = int'(bus.parallel_in);
            else if (m_rise[0]) m_sr = ((m_sr * 2) + int'(m_cond[1])) % 256;
            for (int i = 0; i < 3; i++) begin
                m_rise[i] = 0;
                m_fall[i] = 0;
                if (m_hist[i][1] != m_cond[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > WAIT_TIME) begin
                        m_cond[i] = m_hist[i][1];
                        m_rise[i] = m_hist[i][1];
                        m_fall[i] = !m_hist[i][1];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_hist[i][1] = m_hist[i][0];
                m_hist[i][0] = p[i];
            end
        end
    end

    int sclk_rises = 0;
    int sclk_falls = 0;

    always @(negedge clk) begin
        check("cond", {29'd0, bus.cs_cond, bus.mosi_cond, bus.sclk_cond}, {29'd0, m_cond});
        check("posedge", {29'd0, bus.cs_posedge, bus.mosi_posedge, bus.sclk_posedge}, {29'd0, m_rise});
        check("negedge", {29'd0, bus.cs_negedge, bus.mosi_negedge, bus.sclk_negedge}, {29'd0, m_fall});
        check("parallel_out", {24'd0, bus.parallel_out}, m_sr);
        check("serial_out", {31'd0, bus.serial_out}, {31'd0, m_sr[7]});
        if (bus.sclk_posedge) sclk_rises++;
        if (bus.sclk_negedge) sclk_falls++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic sclk_bit(input bit b);
        bus.mosi_pin = b;
        step(10);
        bus.sclk_pin = 1'b1;
        step(10);
        bus.sclk_pin = 1'b0;
    endtask

    initial begin
        logic [7:0] pattern;
        rst_n = 1'b1;
        bus.sclk_pin = 1'b1; bus.mosi_pin = 1'b1; bus.cs_pin = 1'b1;
        bus.parallel_load = 1'b0; bus.parallel_in = '0;
        #1 rst_n = 1'b0;
        step(3);
        check("rst_outputs", {bus.cs_cond, bus.mosi_cond, bus.sclk_cond, bus.parallel_out,
                              bus.sclk_posedge, bus.sclk_negedge}, 32'd0);
        rst_n = 1'b1;
        step(5);
        check("rst_cond_e5", {29'd0, bus.cs_cond, bus.mosi_cond, bus.sclk_cond}, 32'd0);
        step(1);
        check("rst_cond_e6", {29'd0, bus.cs_cond, bus.mosi_cond, bus.sclk_cond}, 32'd7);
        check("rst_pulse_e6", {29'd0, bus.cs_posedge, bus.mosi_posedge, bus.sclk_posedge}, 32'd7);
        step(1);
        check("rst_pulse_e7", {29'd0, bus.cs_posedge, bus.mosi_posedge, bus.sclk_posedge}, 32'd0);

        bus.sclk_pin = 1'b0; bus.mosi_pin = 1'b0; bus.cs_pin = 1'b0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);
        bus.mosi_pin = 1'b1;
        step(5);
        check("lat_e5", {31'd0, bus.mosi_cond}, 32'd0);
        step(1);
        check("lat_cond_e6", {31'd0, bus.mosi_cond}, 32'd1);
        check("lat_pulse_e6", {31'd0, bus.mosi_posedge}, 32'd1);
        step(1);
        check("lat_pulse_e7", {31'd0, bus.mosi_posedge}, 32'd0);

        sclk_rises = 0; sclk_falls = 0;
        bus.sclk_pin = 1'b1;
        step(2);
        bus.sclk_pin = 1'b0;
        step(12);
        check("glitch_cond", {31'd0, bus.sclk_cond}, 32'd0);
        check("glitch_pulses", sclk_rises + sclk_falls, 32'd0);
        bus.sclk_pin = 1'b1;
        step(6);
        bus.sclk_pin = 1'b0;
        step(12);
        check("wide_rises", sclk_rises, 32'd1);
        check("wide_falls", sclk_falls, 32'd1);

        pattern = 8'hA5;
        for (int i = 7; i >= 0; i--) sclk_bit(pattern[i]);
        step(10);
        check("shift_a5", {24'd0, bus.parallel_out}, 32'hA5);
        check("shift_a5_msb", {31'd0, bus.serial_out}, 32'd1);

        bus.sclk_pin = 1'b1;
        step(6);
        check("load_coincide", {31'd0, bus.sclk_posedge}, 32'd1);
        bus.parallel_load = 1'b1; bus.parallel_in = 8'h3C;
        step(1);
        bus.parallel_load = 1'b0;
        check("load_prio", {24'd0, bus.parallel_out}, 32'h3C);
        step(10);
        bus.sclk_pin = 1'b0;
        sclk_bit(1'b1);
        step(10);
        check("load_shift1", {24'd0, bus.parallel_out}, 32'h79);
        check("load_msb1", {31'd0, bus.serial_out}, 32'd0);
        sclk_bit(1'b1);
        step(10);
        check("load_shift2", {24'd0, bus.parallel_out}, 32'hF3);
        check("load_msb2", {31'd0, bus.serial_out}, 32'd1);

        for (int i = 0; i < 4; i++) sclk_bit(1'($urandom_range(0, 1)));
        step(10);
        bus.mosi_pin = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_po", {24'd0, bus.parallel_out}, 32'd0);
        check("midrst_cond", {29'd0, bus.cs_cond, bus.mosi_cond, bus.sclk_cond}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(5);
        check("midrst_lat_e5", {31'd0, bus.mosi_cond}, 32'd0);
        step(1);
        check("midrst_lat_e6", {31'd0, bus.mosi_cond}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.sclk_pin = ~bus.sclk_pin;
            if ($urandom_range(0, 7) == 0) bus.mosi_pin = ~bus.mosi_pin;
            if ($urandom_range(0, 11) == 0) bus.cs_pin = ~bus.cs_pin;
            bus.parallel_load = ($urandom_range(0, 19) == 0);
            bus.parallel_in   = 8'($urandom);
            rst_n = (c != 1500);
            step(1);
        end
        rst_n = 1'b1;
        bus.parallel_load = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
